sr_flag_arbiter: RTL and testbench

Clocked controller that shares a bank of NFLAGS cross-coupled SR flag latches between two requesters, A and B. It takes set and clear requests, arbitrates them round-robin, and drives one-hot S or R pulses into the latch bank. After each pulse it reads the latch Q back and flags any mismatch. It sits between the control logic that owns the flags and the raw SR latch bank, and guarantees the forbidden S=R=1 input never reaches any latch.

---
 rtl/sr_flag_arbiter_if.sv | 36 +++
 rtl/sr_flag_arbiter.sv | 163 ++++++++++++++++
 tb/tb_sr_flag_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_flag_arbiter_if.sv
// Request/ack handshake for requesters A and B plus the S/R drive and Q
// read-back lines of the latch bank, bundled for the flag arbiter.
interface sr_flag_arbiter_if #(
  parameter int unsigned NFLAGS = 4,
  parameter int unsigned IDXW   = 2
);
  logic              a_req;
  logic              a_op;
  logic [IDXW-1:0]   a_idx;
  logic              a_ack;
  logic              b_req;
  logic              b_op;
  logic [IDXW-1:0]   b_idx;
  logic              b_ack;
  logic [NFLAGS-1:0] s_out;
  logic [NFLAGS-1:0] r_out;
  logic [NFLAGS-1:0] q_in;
  logic              busy;
  logic              err;

  // Requesters and latch bank side: issue requests, return latch Q.
  modport master (
    output a_req, a_op, a_idx,
    output b_req, b_op, b_idx,
    output q_in,
    input  a_ack, b_ack, s_out, r_out, busy, err
  );

  // Arbiter side: accept requests, drive the latch bank.
  modport slave (
    input  a_req, a_op, a_idx,
    input  b_req, b_op, b_idx,
    input  q_in,
    output a_ack, b_ack, s_out, r_out, busy, err
  );
endinterface

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that shares a bank of SR flag latches between two
// requesters. Each granted request becomes a single S or R pulse of
// PULSE_LEN cycles, followed by a one-cycle Q read-back check. S and R are
// never high together and at most one latch is driven at a time.
module sr_flag_arbiter #(
  parameter int unsigned NFLAGS    = 4,
  parameter int unsigned IDXW      = 2,
  parameter int unsigned PULSE_LEN = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  sr_flag_arbiter_if.slave bus
);

  localparam int unsigned CNTW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(PULSE_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    CHECK = 2'd2
  } state_e;

  // Captured request payload: operation (1 = set, 0 = clear) and target.
  typedef struct packed {
    logic            op;
    logic [IDXW-1:0] idx;
  } req_t;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  req_t              cur_q, cur_d;
  logic              owner_q, owner_d;     // 0 = A, 1 = B
  logic              prio_b_q, prio_b_d;   // B wins the next tie when set
  logic [NFLAGS-1:0] s_out_q, s_out_d;
  logic [NFLAGS-1:0] r_out_q, r_out_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  req_t              a_pl_c;
  req_t              b_pl_c;
  logic [NFLAGS-1:0] cur_oh_c;
  logic              q_bit_c;
  logic              in_range_c;

  // One-hot select of a flag index; all-zero when the index is out of range.
  function automatic logic [NFLAGS-1:0] decode(input logic [IDXW-1:0] idx);
    logic [NFLAGS-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < NFLAGS; i++) begin
      oh[i] = (32'(idx) == i);
    end
    return oh;
  endfunction

  // Request payloads and read-back of the latch addressed by the current op.
  assign a_pl_c     = '{op: bus.a_op, idx: bus.a_idx};
  assign b_pl_c     = '{op: bus.b_op, idx: bus.b_idx};
  assign cur_oh_c   = decode(cur_q.idx);
  assign in_range_c = |cur_oh_c;
  assign q_bit_c    = |(bus.q_in & cur_oh_c);

  // State, payload and registered outputs; reset drops any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cur_q    <= '0;
      owner_q  <= 1'b0;
      prio_b_q <= 1'b0;
      s_out_q  <= '0;
      r_out_q  <= '0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cur_q    <= cur_d;
      owner_q  <= owner_d;
      prio_b_q <= prio_b_d;
      s_out_q  <= s_out_d;
      r_out_q  <= r_out_d;
      a_ack_q  <= a_ack_d;
      b_ack_q  <= b_ack_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  // Next state and next registered outputs; the values computed here are
  // what the outputs show in the following cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cur_d    = cur_q;
    owner_d  = owner_q;
    prio_b_d = prio_b_q;
    s_out_d  = '0;
    r_out_d  = '0;
    a_ack_d  = 1'b0;
    b_ack_d  = 1'b0;
    busy_d   = 1'b0;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (bus.a_req || bus.b_req) begin
          // Tie goes to whoever was not served last.
          owner_d = (bus.a_req && bus.b_req) ? prio_b_q : bus.b_req;
          cur_d   = owner_d ? b_pl_c : a_pl_c;
          cnt_d   = '0;
          state_d = PULSE;
          busy_d  = 1'b1;
          if (cur_d.op) begin
            s_out_d = decode(cur_d.idx);
          end else begin
            r_out_d = decode(cur_d.idx);
          end
        end
      end

      PULSE: begin
        busy_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Pulse ends; the ack is shown during the check cycle.
          state_d = CHECK;
          a_ack_d = ~owner_q;
          b_ack_d = owner_q;
        end else begin
          cnt_d   = cnt_q + CNTW'(1);
          s_out_d = s_out_q;
          r_out_d = r_out_q;
        end
      end

      CHECK: begin
        // S/R have been low for a full cycle, so Q has settled.
        if (!in_range_c || (q_bit_c != cur_q.op)) begin
          err_d = 1'b1;
        end
        prio_b_d = ~owner_q;
        cnt_d    = '0;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.s_out = s_out_q;
  assign bus.r_out = r_out_q;
  assign bus.a_ack = a_ack_q;
  assign bus.b_ack = b_ack_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter: behavioural SR latch bank, a transaction-level
// model checked every cycle, and directed scenarios with literal expectations.
module tb_sr_flag_arbiter;

  localparam int unsigned NFLAGS = 4;
  localparam int unsigned IDXW   = 3;
  localparam int unsigned P      = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sr_flag_arbiter_if #(.NFLAGS(NFLAGS), .IDXW(IDXW)) bus ();

  sr_flag_arbiter #(.NFLAGS(NFLAGS), .IDXW(IDXW), .PULSE_LEN(P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vec  = 0;
  int miss = 0;
  int cyc  = 0;

  // Latch bank: settles at the clock edge, keeps state across reset.
  logic [NFLAGS-1:0] q_lat  = '0;
  logic [NFLAGS-1:0] q_mask = '0;
  assign bus.q_in = q_lat & ~q_mask;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NFLAGS; i++) begin
      if (bus.s_out[i]) q_lat[i] <= 1'b1;
      else if (bus.r_out[i]) q_lat[i] <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction model: one op in flight, outputs derived from cycles since grant.
  bit              m_act;
  bit              m_own;
  bit              m_prio_b;
  bit              m_op;
  bit              m_err;
  int              m_k;
  logic [IDXW-1:0] m_idx;
  logic [NFLAGS-1:0] e_s, e_r;
  bit              e_a, e_b, e_busy;
  bit              ack_log[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      m_act = 0; m_prio_b = 0; m_err = 0; m_k = 0;
    end else begin
      e_s = '0; e_r = '0; e_a = 0; e_b = 0; e_busy = 0;
      if (m_act) begin
        e_busy = 1;
        if (m_k <= P) begin
          if (32'(m_idx) < NFLAGS) begin
            if (m_op) e_s = NFLAGS'(1) << m_idx;
            else      e_r = NFLAGS'(1) << m_idx;
          end
        end else begin
          if (m_own) e_b = 1; else e_a = 1;
        end
      end
      chk("model_s_out", bus.s_out, e_s);
      chk("model_r_out", bus.r_out, e_r);
      chk("model_a_ack", bus.a_ack, e_a);
      chk("model_b_ack", bus.b_ack, e_b);
      chk("model_busy",  bus.busy,  e_busy);
      chk("model_err",   bus.err,   m_err);
      chk("inv_s_and_r", bus.s_out & bus.r_out, 0);
      chk("inv_onehot",  $countones(bus.s_out | bus.r_out) <= 1, 1);
      if (bus.a_ack) ack_log.push_back(1'b0);
      if (bus.b_ack) ack_log.push_back(1'b1);
      // advance to next cycle
      if (m_act) begin
        if (m_k == P + 1) begin
          if (32'(m_idx) >= NFLAGS) m_err = 1;
          else if (bus.q_in[m_idx] != m_op) m_err = 1;
          m_prio_b = !m_own;
          m_act = 0;
        end else begin
          m_k++;
        end
      end else if (bus.a_req || bus.b_req) begin
        m_own = (bus.a_req && bus.b_req) ? m_prio_b : bus.b_req;
        m_op  = m_own ? bus.b_op  : bus.a_op;
        m_idx = m_own ? bus.b_idx : bus.a_idx;
        m_act = 1;
        m_k   = 1;
      end
    end
  end

  // Hold a request until its ack, then release on the edge ending the ack cycle.
  task automatic do_req(input bit side, input bit op, input logic [IDXW-1:0] idx,
                        output int ack_cyc);
    bit got;
    got = 0;
    ack_cyc = -1;
    if (side) begin bus.b_req = 1; bus.b_op = op; bus.b_idx = idx; end
    else      begin bus.a_req = 1; bus.a_op = op; bus.a_idx = idx; end
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (side ? bus.b_ack : bus.a_ack) begin
        got = 1;
        ack_cyc = cyc;
      end
    end
    chk(side ? "b_ack_seen" : "a_ack_seen", 32'(got), 1);
    @(posedge clk); #1;
    if (side) bus.b_req = 0; else bus.a_req = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); #1 rst_n = 0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_out"}, bus.s_out, 0);
    chk({tag, "_r_out"}, bus.r_out, 0);
    chk({tag, "_a_ack"}, bus.a_ack, 0);
    chk({tag, "_b_ack"}, bus.b_ack, 0);
    chk({tag, "_busy"},  bus.busy,  0);
    chk({tag, "_err"},   bus.err,   0);
  endtask

  int t0, ca, cb;
  int ac[3];
  int bc[3];

  initial begin
    bus.a_req = 0; bus.a_op = 0; bus.a_idx = '0;
    bus.b_req = 0; bus.b_op = 0; bus.b_idx = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("por");
    #1 rst_n = 1;

    // Single set of flag 2 by A.
    @(posedge clk); #1;
    bus.a_req = 1; bus.a_op = 1; bus.a_idx = 3'd2;
    @(negedge clk); chk("set_c0_busy", bus.busy, 0);
    @(negedge clk); chk("set_c1_s", bus.s_out, 4'b0100); chk("set_c1_r", bus.r_out, 0);
    @(negedge clk); chk("set_c2_s", bus.s_out, 4'b0100);
    @(negedge clk); chk("set_c3_ack", bus.a_ack, 1); chk("set_c3_s", bus.s_out, 0);
    chk("set_c3_q2", bus.q_in[2], 1);
    @(posedge clk); #1 bus.a_req = 0;
    @(negedge clk); chk("set_c4_err", bus.err, 0); chk("set_c4_busy", bus.busy, 0);

    // Set and clear of flag 1 in the same cycle.
    do_reset();
    @(posedge clk); #1 t0 = cyc;
    fork
      do_req(1'b0, 1'b1, 3'd1, ca);
      do_req(1'b1, 1'b0, 3'd1, cb);
    join
    chk("conf_a_ack_cyc", ca - t0, 3);
    chk("conf_b_ack_cyc", cb - t0, 7);
    chk("conf_latch1", q_lat[1], 0);

    // Both saturated for six operations.
    do_reset();
    ack_log.delete();
    @(posedge clk); #1 t0 = cyc;
    fork
      begin for (int i = 0; i < 3; i++) do_req(1'b0, 1'b1, 3'(i), ac[i]); end
      begin for (int j = 0; j < 3; j++) do_req(1'b1, 1'b0, 3'(j), bc[j]); end
    join
    for (int i = 0; i < 3; i++) begin
      chk("fair_a_cyc", ac[i] - t0, 3 + 8 * i);
      chk("fair_b_cyc", bc[i] - t0, 7 + 8 * i);
    end
    chk("fair_log_len", ack_log.size(), 6);
    for (int i = 0; i < ack_log.size() && i < 6; i++) chk("fair_order", ack_log[i], i % 2);

    // Read-back mismatch on flag 0.
    do_reset();
    q_mask = 4'b0001;
    @(posedge clk); #1 t0 = cyc;
    do_req(1'b0, 1'b1, 3'd0, ca);
    chk("qerr_ack_cyc", ca - t0, 3);
    @(negedge clk); chk("qerr_err_rise", bus.err, 1);
    repeat (3) @(negedge clk);
    chk("qerr_err_sticky", bus.err, 1);
    q_mask = '0;

    // Out-of-range index.
    do_reset();
    @(negedge clk); chk("oor_err_cleared", bus.err, 0);
    @(posedge clk); #1;
    bus.a_req = 1; bus.a_op = 1; bus.a_idx = 3'd5;
    @(negedge clk);
    @(negedge clk); chk("oor_c1_s", bus.s_out, 0); chk("oor_c1_busy", bus.busy, 1);
    @(negedge clk); chk("oor_c2_sr", bus.s_out | bus.r_out, 0);
    @(negedge clk); chk("oor_c3_ack", bus.a_ack, 1);
    @(posedge clk); #1 bus.a_req = 0;
    @(negedge clk); chk("oor_c4_err", bus.err, 1);

    // Reset in the middle of a pulse (err is high going in).
    @(posedge clk); #1;
    bus.a_req = 1; bus.a_op = 1; bus.a_idx = 3'd3;
    @(negedge clk);
    @(negedge clk); chk("mid_c1_s", bus.s_out, 4'b1000);
    #1 rst_n = 0;
    #1 chk_all_zero("mid_rst");
    bus.a_req = 0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_no_ack", {bus.a_ack, bus.b_ack}, 0);
    end
    @(posedge clk); #1 t0 = cyc;
    fork
      do_req(1'b0, 1'b0, 3'd2, ca);
      do_req(1'b1, 1'b1, 3'd2, cb);
    join
    chk("mid_a_first", ca - t0, 3);
    chk("mid_b_second", cb - t0, 7);
    chk("mid_latch2", q_lat[2], 1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    miss++;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $fatal(1, "watchdog");
  end

endmodule
